// File: rtl/deal_ctrl_if.sv
// Bundle of user controls, card source and score/result signals for the blackjack sequencer.
// master drives start/hit/stand/card_in; slave (the sequencer) drives card_en and status.
interface deal_ctrl_if;
    logic       start;
    logic       hit;
    logic       stand;
    logic [3:0] card_in;
    logic       card_en;
    logic [4:0] player_score;
    logic [4:0] dealer_score;
    logic       player_bust;
    logic       dealer_bust;
    logic [1:0] result;
    logic       busy;
    logic       done;

    modport master (
        output start, hit, stand, card_in,
        input  card_en, player_score, dealer_score, player_bust, dealer_bust, result, busy, done
    );

    modport slave (
        input  start, hit, stand, card_in,
        output card_en, player_score, dealer_score, player_bust, dealer_bust, result, busy, done
    );
endinterface

// File: rtl/deal_ctrl.sv
// Blackjack round sequencer: draws cards via one-cycle card_en, keeps both hands, decides the result.
// Each card costs a DRAW+CAP pair (2 cycles, +2 per zero redraw); no backpressure, inputs are levels.
module deal_ctrl #(
    parameter int DEALER_STAND = 17,
    parameter int BUST_LIMIT   = 21,
    parameter int MAX_CARDS    = 8
) (
    input  logic        clk,
    input  logic        reset,
    deal_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {S_IDLE, S_DRAW, S_CAP, S_PLAYER, S_DEALER, S_DONE} state_t;
    typedef enum logic [1:0] {PH_DEAL, PH_PLAYER, PH_DEALER} phase_t;

    localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
    localparam logic [4:0] BUST_L  = 5'(BUST_LIMIT);
    localparam logic [3:0] MAX_L   = 4'(MAX_CARDS);

    function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 6'd31) ? 5'd31 : s[4:0];
    endfunction

    function automatic logic [4:0] best_of(input logic [4:0] hard, input logic ace);
        return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
    endfunction

    state_t     state_q, state_d;
    phase_t     phase_q, phase_d;
    logic [1:0] deal_cnt_q, deal_cnt_d;
    logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [3:0] p_cnt_q, p_cnt_d, d_cnt_q, d_cnt_d;
    logic [1:0] result_q, result_d;

    logic [4:0] card_val, p_new_hard, d_new_hard, p_best, d_best;
    logic       card_ace, to_player, p_bust, d_bust;

    assign card_val   = (bus.card_in > 4'd10) ? 5'd10 : {1'b0, bus.card_in};
    assign card_ace   = (bus.card_in == 4'd1);
    // Deal order alternates P,D,P,D, so even deal slots belong to the player.
    assign to_player  = (phase_q == PH_PLAYER) || (phase_q == PH_DEAL && !deal_cnt_q[0]);
    assign p_new_hard = sat_add(p_hard_q, card_val);
    assign d_new_hard = sat_add(d_hard_q, card_val);
    assign p_best     = best_of(p_hard_q, p_ace_q);
    assign d_best     = best_of(d_hard_q, d_ace_q);
    assign p_bust     = (p_hard_q > BUST_L);
    assign d_bust     = (d_hard_q > BUST_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_DEAL;
            deal_cnt_q <= 2'd0;
            p_hard_q   <= 5'd0;
            d_hard_q   <= 5'd0;
            p_ace_q    <= 1'b0;
            d_ace_q    <= 1'b0;
            p_cnt_q    <= 4'd0;
            d_cnt_q    <= 4'd0;
            result_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            deal_cnt_q <= deal_cnt_d;
            p_hard_q   <= p_hard_d;
            d_hard_q   <= d_hard_d;
            p_ace_q    <= p_ace_d;
            d_ace_q    <= d_ace_d;
            p_cnt_q    <= p_cnt_d;
            d_cnt_q    <= d_cnt_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        deal_cnt_d = deal_cnt_q;
        p_hard_d   = p_hard_q;
        d_hard_d   = d_hard_q;
        p_ace_d    = p_ace_q;
        d_ace_d    = d_ace_q;
        p_cnt_d    = p_cnt_q;
        d_cnt_d    = d_cnt_q;
        result_d   = result_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    phase_d    = PH_DEAL;
                    deal_cnt_d = 2'd0;
                    p_hard_d   = 5'd0;
                    d_hard_d   = 5'd0;
                    p_ace_d    = 1'b0;
                    d_ace_d    = 1'b0;
                    p_cnt_d    = 4'd0;
                    d_cnt_d    = 4'd0;
                    result_d   = 2'b00;
                    state_d    = S_DRAW;
                end
            end
            S_DRAW: state_d = S_CAP;
            S_CAP: begin
                if (bus.card_in == 4'd0) begin
                    state_d = S_DRAW;
                end else begin
                    if (to_player) begin
                        p_hard_d = p_new_hard;
                        p_ace_d  = p_ace_q | card_ace;
                        p_cnt_d  = p_cnt_q + 4'd1;
                    end else begin
                        d_hard_d = d_new_hard;
                        d_ace_d  = d_ace_q | card_ace;
                        d_cnt_d  = d_cnt_q + 4'd1;
                    end
                    unique case (phase_q)
                        PH_DEAL: begin
                            if (deal_cnt_q == 2'd3) begin
                                phase_d = PH_PLAYER;
                                state_d = S_PLAYER;
                            end else begin
                                deal_cnt_d = deal_cnt_q + 2'd1;
                                state_d    = S_DRAW;
                            end
                        end
                        PH_PLAYER: begin
                            // A player bust ends the round before the dealer draws.
                            if (p_new_hard > BUST_L) begin
                                result_d = 2'b10;
                                state_d  = S_DONE;
                            end else begin
                                state_d = S_PLAYER;
                            end
                        end
                        default: state_d = S_DEALER;
                    endcase
                end
            end
            S_PLAYER: begin
                if (bus.stand || p_cnt_q == MAX_L || p_best == BUST_L) begin
                    phase_d = PH_DEALER;
                    state_d = S_DEALER;
                end else if (bus.hit) begin
                    state_d = S_DRAW;
                end
            end
            S_DEALER: begin
                if (d_best >= STAND_L || d_cnt_q == MAX_L) begin
                    state_d = S_DONE;
                    if (p_bust)               result_d = 2'b10;
                    else if (d_bust)          result_d = 2'b01;
                    else if (p_best > d_best) result_d = 2'b01;
                    else if (p_best < d_best) result_d = 2'b10;
                    else                      result_d = 2'b11;
                end else begin
                    state_d = S_DRAW;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.card_en      = (state_q == S_DRAW);
    assign bus.player_score = p_best;
    assign bus.dealer_score = d_best;
    assign bus.player_bust  = p_bust;
    assign bus.dealer_bust  = d_bust;
    assign bus.result       = result_q;
    assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done         = (state_q == S_DONE);

endmodule

// File: tb/tb_deal_ctrl.sv
// Directed bench for deal_ctrl: a scripted card deck answers each card_en, rounds are checked against hand-computed totals.
module tb_deal_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    deal_ctrl_if bus();

    deal_ctrl #(.DEALER_STAND(17), .BUST_LIMIT(21), .MAX_CARDS(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int deck[$];
    int en_cyc[$];
    int en_count = 0;
    int b2b = 0;
    int base = 0;
    bit prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Card source: answers each visible card_en with the next deck value (0 when the deck is empty).
    initial begin
        bus.card_in = 4'd0;
        forever begin
            @(negedge clk);
            if (bus.card_en === 1'b1) begin
                if (prev_en) b2b++;
                en_count++;
                en_cyc.push_back(cyc);
                if (deck.size() > 0) bus.card_in = 4'(deck.pop_front());
                else                 bus.card_in = 4'd0;
            end
            prev_en = (bus.card_en === 1'b1);
        end
    end

    task automatic play(input logic h, input logic s, input int nstart);
        base     = en_count;
        bus.hit  = h;
        bus.stand = s;
        @(negedge clk);
        bus.start = 1'b1;
        repeat (nstart) @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic wait_en(input string tag, input int n);
        bit got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (en_count - base >= n) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_en_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_round(input string tag, input int ps, input int ds, input int pb,
                               input int db, input int res, input int ncards);
        chk({tag, "_pscore"}, 32'(bus.player_score), 32'(ps));
        chk({tag, "_dscore"}, 32'(bus.dealer_score), 32'(ds));
        chk({tag, "_pbust"},  32'(bus.player_bust),  32'(pb));
        chk({tag, "_dbust"},  32'(bus.dealer_bust),  32'(db));
        chk({tag, "_result"}, 32'(bus.result),       32'(res));
        chk({tag, "_busy"},   32'(bus.busy),         32'd0);
        chk({tag, "_cards"},  32'(en_count - base),  32'(ncards));
    endtask

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.hit   = 1'b0;
        bus.stand = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_card_en", 32'(bus.card_en),      32'd0);
        chk("rst_busy",    32'(bus.busy),         32'd0);
        chk("rst_done",    32'(bus.done),         32'd0);
        chk("rst_result",  32'(bus.result),       32'd0);
        chk("rst_pscore",  32'(bus.player_score), 32'd0);
        chk("rst_dscore",  32'(bus.dealer_score), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Pushed 17/17; start held high into the deal must not restart it.
        deck = '{10, 9, 7, 8};
        play(1'b0, 1'b1, 3);
        wait_done("t1");
        check_round("t1", 17, 17, 0, 0, 3, 4);
        repeat (5) @(negedge clk);
        chk("t1_hold_done",   32'(bus.done),         32'd1);
        chk("t1_hold_pscore", 32'(bus.player_score), 32'd17);

        // Soft 21 goes straight to the dealer, who draws 10 onto 11.
        deck = '{1, 5, 10, 6, 10};
        play(1'b0, 1'b0, 1);
        wait_done("t2");
        check_round("t2", 21, 21, 0, 0, 3, 5);

        // Player 16 hits a 9 and busts; dealer keeps two cards.
        deck = '{10, 10, 6, 7, 9};
        play(1'b1, 1'b0, 1);
        wait_done("t3");
        check_round("t3", 25, 17, 1, 0, 2, 5);

        // Zero card triggers a redraw two cycles later; 15 counts as 10.
        deck = '{0, 10, 15, 7, 8};
        play(1'b0, 1'b1, 1);
        wait_en("t4", 2);
        chk("t4_hold_zero",  32'(bus.player_score), 32'd0);
        chk("t4_redraw_gap", 32'(en_cyc[base+1] - en_cyc[base]), 32'd2);
        wait_done("t4");
        check_round("t4", 17, 18, 0, 0, 2, 5);

        // Dealer 16 draws an ace to hard 17 and stops; player 11 loses.
        deck = '{5, 10, 6, 6, 1};
        play(1'b0, 1'b1, 1);
        wait_done("t5");
        check_round("t5", 11, 17, 0, 0, 2, 5);

        // Eight-card cap forces the player to stand at soft 18.
        deck = '{1, 10, 1, 6, 1, 1, 1, 1, 1, 1, 1};
        play(1'b1, 1'b0, 1);
        wait_done("t7");
        check_round("t7", 18, 17, 0, 0, 1, 11);
        deck.delete();

        // Reset during the player's hit draw, then a clean round.
        deck = '{10, 6, 10, 7};
        play(1'b1, 1'b0, 1);
        wait_en("t6", 5);
        #1 reset = 1'b0;
        #1;
        chk("t6_card_en", 32'(bus.card_en),      32'd0);
        chk("t6_busy",    32'(bus.busy),         32'd0);
        chk("t6_done",    32'(bus.done),         32'd0);
        chk("t6_pscore",  32'(bus.player_score), 32'd0);
        chk("t6_dscore",  32'(bus.dealer_score), 32'd0);
        chk("t6_result",  32'(bus.result),       32'd0);
        @(negedge clk);
        reset = 1'b1;
        deck.delete();
        deck = '{2, 3, 4, 5, 10};
        play(1'b0, 1'b1, 1);
        wait_done("t6b");
        check_round("t6b", 6, 18, 0, 0, 2, 5);

        chk("no_b2b_card_en", 32'(b2b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
